// File: rtl/register_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : register_shift_unit
//  Purpose  : Operand registers A/B loaded from the mux output, with a
//             command-driven WIDTH-cycle serial right shift of the A:B pair.
//  Revision : 1.0  initial release
// ============================================================================
module register_shift_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    // Counter value present on the edge that performs the final shift.
    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             w_any_load;

    assign w_any_load = LoadA | LoadB;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A load takes priority over starting a shift.
                    if (LoadA) r_a <= D;
                    if (LoadB) r_b <= D;
                    if (!w_any_load && Execute) begin
                        r_state <= c_SHIFT;
                        r_count <= '0;
                    end
                end
                c_SHIFT: begin
                    r_a     <= {Shift_In, r_a[WIDTH-1:1]};
                    r_b     <= {r_a[0], r_b[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST_CNT) begin
                        r_state <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    // Wait for Execute release so one command yields one sequence.
                    if (!Execute) r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign A_out = r_a;
    assign B_out = r_b;
    assign Busy  = (r_state == c_SHIFT);
    assign Done  = (r_state == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_register_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_shift_unit
//  Purpose  : Scoreboard bench for register_shift_unit with a behavioural
//             reference model, directed scenarios and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_shift_unit;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic [W-1:0] D;
    logic         LoadA;
    logic         LoadB;
    logic         Execute;
    logic         Shift_In;
    logic [W-1:0] A_out;
    logic [W-1:0] B_out;
    logic         Busy;
    logic         Done;

    register_shift_unit #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .D        (D),
        .LoadA    (LoadA),
        .LoadB    (LoadB),
        .Execute  (Execute),
        .Shift_In (Shift_In),
        .A_out    (A_out),
        .B_out    (B_out),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected post-edge outputs packed as {A, B, Busy, Done}.
    logic [2*W+1:0] q_exp[$];

    // Reference model: mode 0 = idle, 1 = shifting, 2 = holding.
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    int           m_mode = 0;
    int           m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W+1:0] model_out();
        return {m_a, m_b, (m_mode == 1), (m_mode == 2)};
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_mode = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic la, input logic lb, input logic ex,
                              input logic si, input logic [W-1:0] d);
        logic [2*W:0] pair;
        case (m_mode)
            0: begin
                if (la || lb) begin
                    if (la) m_a = d;
                    if (lb) m_b = d;
                end else if (ex) begin
                    m_mode = 1;
                    m_cnt  = 0;
                end
            end
            1: begin
                pair = {si, m_a, m_b} >> 1;
                m_a  = pair[2*W-1:W];
                m_b  = pair[W-1:0];
                m_cnt++;
                if (m_cnt == W) m_mode = 2;
            end
            default: if (!ex) m_mode = 0;
        endcase
    endtask

    task automatic step(input logic la, input logic lb, input logic ex,
                        input logic si, input logic [W-1:0] d, input logic rst);
        LoadA = la; LoadB = lb; Execute = ex; Shift_In = si; D = d; Reset = rst;
        @(posedge Clk);
        if (rst) model_reset();
        else     model_edge(la, lb, ex, si, d);
        q_exp.push_back(model_out());
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string name);
        q_exp.delete();
        Reset = 1'b1;
        model_reset();
        #1;
        check({name, "_async"}, {14'd0, A_out, B_out, Busy, Done}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        Reset = 1'b0;
    endtask

    always @(negedge Clk) begin
        logic [2*W+1:0] e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check("scoreboard", {14'd0, A_out, B_out, Busy, Done}, {14'd0, e});
        end
    end

    initial begin
        int busy_cnt;
        logic ex_r;
        Reset = 1'b1; D = '0; LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b0; Shift_In = 1'b0;
        #1;
        check("reset_state", {14'd0, A_out, B_out, Busy, Done}, 32'd0);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 0);

        // Loads
        step(1, 0, 0, 0, 8'h8C, 0);
        step(0, 1, 0, 0, 8'h3F, 0);
        check("load_a", A_out, 8'h8C);
        check("load_b", B_out, 8'h3F);
        step(1, 1, 0, 0, 8'h5A, 0);
        check("load_both", {A_out, B_out}, 16'h5A5A);

        do_reset("reset_midstream");

        // Full shift with LoadA interference during SHIFT and HOLD
        step(1, 0, 0, 0, 8'h8C, 0);
        step(0, 1, 0, 0, 8'h3F, 0);
        step(0, 0, 1, 0, 8'h00, 0);
        busy_cnt = int'(Busy);
        for (int i = 1; i <= W; i++) begin
            step(1, 0, 1, 0, 8'hFF, 0);
            busy_cnt += int'(Busy);
            if (i == 4) check("shift4", {A_out, B_out}, 16'h08C3);
        end
        check("shift8", {A_out, B_out}, 16'h008C);
        check("done_after8", Done, 1'b1);
        check("busy_cycles", busy_cnt, W);
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 8'hFF, 0);
        check("hold_frozen", {A_out, B_out, Busy, Done}, {16'h008C, 2'b01});
        step(0, 0, 0, 0, '0, 0);
        check("release_idle", {Busy, Done}, 2'b00);
        step(0, 0, 1, 0, '0, 0);
        for (int i = 0; i < W; i++) step(0, 0, 1, 0, '0, 0);
        check("second_seq", {A_out, B_out, Done}, {16'h0000, 1'b1});
        step(0, 0, 0, 0, '0, 0);

        // Load wins over Execute in IDLE
        step(1, 0, 1, 0, 8'h8C, 0);
        check("load_over_exec", {A_out, Busy}, {8'h8C, 1'b0});

        // Reset after 3 shifts
        step(0, 0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0, 0);
        do_reset("reset_midshift");
        step(0, 0, 0, 0, '0, 0);
        check("idle_after_reset", {Busy, Done}, 2'b00);

        // Shift_In = 1, Execute dropped mid-sequence
        step(1, 0, 0, 0, 8'h8C, 0);
        step(0, 1, 0, 0, 8'h3F, 0);
        step(0, 0, 1, 1, '0, 0);
        for (int i = 0; i < W; i++) step(0, 0, 1'(i < 2), 1, '0, 0);
        check("shiftin1", {A_out, B_out, Done}, {16'hFF8C, 1'b1});
        step(0, 0, 0, 1, '0, 0);
        check("hold_one_cycle", Done, 1'b0);

        // Randomized traffic against the model
        ex_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("reset_random");
            end else begin
                if ($urandom_range(0, 5) == 0) ex_r = ~ex_r;
                step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                     ex_r, 1'($urandom), 8'($urandom), 0);
            end
        end

        step(0, 0, 0, 0, '0, 0);
        @(negedge Clk);
        #1;
        check("drain", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
